// File: rtl/evp_fsm.sv
// evp_fsm: evaluates the stored polynomial in slot A at point x with Horner's
// method. Degree comes from N RAM, coefficients c0..cN from S RAM at
// A*11 .. A*11+N (walked highest coefficient first). One result word and one
// status word are written to the output FIFOs, then done_evp pulses.
module evp_fsm #(
    parameter int word_size = 16,
    parameter int n_size    = 8,
    parameter int s_size    = 88
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_evp,
    input  logic [2:0]                A,
    input  logic [word_size-1:0]      x,
    input  logic [4:0]                rd_data_N,
    input  logic [word_size-1:0]      rd_data_S,
    output logic                      en_rd_N,
    output logic [$clog2(n_size)-1:0] rd_addr_N,
    output logic                      en_rd_S,
    output logic [$clog2(s_size)-1:0] rd_addr_S,
    output logic [31:0]               result,
    output logic [31:0]               status,
    output logic                      en_wr_result,
    output logic                      en_wr_status,
    output logic                      done_evp
);

    localparam int NA          = $clog2(n_size);
    localparam int SA          = $clog2(s_size);
    // acc(32) * x(word_size) + coefficient(word_size) needs one carry bit
    localparam int FW          = 32 + word_size + 1;
    localparam int SLOT_STRIDE = 11;
    localparam logic [4:0] MAX_DEGREE = 5'd10;

    localparam logic [31:0] STATUS_OK       = 32'd0;
    localparam logic [31:0] STATUS_OVERFLOW = 32'd1;
    localparam logic [31:0] STATUS_BAD_SLOT = 32'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_N,
        WAIT_N,
        RD_C,
        MAC,
        ERR,
        OUT,
        END
    } state_t;

    state_t                 state_reg;
    logic [2:0]             a_reg;
    logic [word_size-1:0]   x_reg;
    // idx starts at the degree read from N RAM, so it doubles as the
    // latched degree; no separate copy is needed afterwards.
    logic [3:0]             idx_reg;
    logic [31:0]            acc_reg;
    logic                   ovf_reg;
    logic [31:0]            result_reg;
    logic [31:0]            status_reg;

    logic [FW-1:0]          full;
    logic                   ovf_now;
    logic [SA-1:0]          s_addr;

    // One Horner step; the product is widened so no bit is lost before the
    // overflow test on the upper bits.
    assign full    = FW'(acc_reg) * FW'(x_reg) + FW'(rd_data_S);
    assign ovf_now = |full[FW-1:32];

    // Coefficient address: slot base plus current index (max 87, no wrap).
    assign s_addr = SA'(a_reg) * SA'(SLOT_STRIDE) + SA'(idx_reg);

    // RAM strobes, FIFO strobes and addresses are decoded from the state.
    assign en_rd_N      = (state_reg == RD_N);
    assign rd_addr_N    = (state_reg == RD_N) ? NA'(a_reg) : '0;
    assign en_rd_S      = (state_reg == RD_C);
    assign rd_addr_S    = (state_reg == RD_C) ? s_addr : '0;
    assign en_wr_result = (state_reg == OUT);
    assign en_wr_status = (state_reg == OUT);
    assign done_evp     = (state_reg == END);
    assign result       = result_reg;
    assign status       = status_reg;

    // Sequencer and datapath registers; result/status are loaded on the way
    // into OUT so they are valid during the FIFO write and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            x_reg      <= '0;
            idx_reg    <= '0;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
            result_reg <= '0;
            status_reg <= 32'hFFFF_FFFF;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_evp) begin
                        a_reg     <= A;
                        x_reg     <= x;
                        state_reg <= RD_N;
                    end
                end
                RD_N: begin
                    state_reg <= WAIT_N;
                end
                WAIT_N: begin
                    // Unwritten slots read back as 5'b11111 and land here too.
                    if (rd_data_N > MAX_DEGREE) begin
                        state_reg <= ERR;
                    end else begin
                        idx_reg   <= rd_data_N[3:0];
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= RD_C;
                    end
                end
                RD_C: begin
                    state_reg <= MAC;
                end
                MAC: begin
                    acc_reg <= full[31:0];
                    ovf_reg <= ovf_reg | ovf_now;
                    if (idx_reg == 4'd0) begin
                        result_reg <= full[31:0];
                        status_reg <= (ovf_reg | ovf_now) ? STATUS_OVERFLOW : STATUS_OK;
                        state_reg  <= OUT;
                    end else begin
                        idx_reg   <= idx_reg - 4'd1;
                        state_reg <= RD_C;
                    end
                end
                ERR: begin
                    result_reg <= '0;
                    status_reg <= STATUS_BAD_SLOT;
                    state_reg  <= OUT;
                end
                OUT: begin
                    state_reg <= END;
                end
                END: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evp_fsm.sv
// Testbench for evp_fsm: table of EVP operations with expected results, a
// scoreboard fed at start and drained at each FIFO write, and hand-written
// sequences for mid-operation reset and an ignored start pulse.
module tb_evp_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_evp;
    logic [2:0]  A;
    logic [15:0] x;
    logic [4:0]  rd_data_N;
    logic [15:0] rd_data_S;
    logic        en_rd_N;
    logic [2:0]  rd_addr_N;
    logic        en_rd_S;
    logic [6:0]  rd_addr_S;
    logic [31:0] result;
    logic [31:0] status;
    logic        en_wr_result;
    logic        en_wr_status;
    logic        done_evp;

    evp_fsm #(.word_size(16), .n_size(8), .s_size(88)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_evp    (start_evp),
        .A            (A),
        .x            (x),
        .rd_data_N    (rd_data_N),
        .rd_data_S    (rd_data_S),
        .en_rd_N      (en_rd_N),
        .rd_addr_N    (rd_addr_N),
        .en_rd_S      (en_rd_S),
        .rd_addr_S    (rd_addr_S),
        .result       (result),
        .status       (status),
        .en_wr_result (en_wr_result),
        .en_wr_status (en_wr_status),
        .done_evp     (done_evp)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM models
    logic [4:0]  nram [8];
    logic [15:0] sram [88];

    always @(posedge clk) begin
        if (en_rd_N) rd_data_N <= nram[rd_addr_N];
        if (en_rd_S) rd_data_S <= sram[rd_addr_S];
    end

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [2:0]  slot;
        logic [15:0] xv;
        logic [4:0]  deg;
        logic [15:0] c [11];
        logic [31:0] res;
        logic [31:0] st;
    } vec_t;

    vec_t vecs [8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard drain: each FIFO write must match the oldest pending EVP.
    always @(negedge clk) begin
        if (en_wr_result) begin
            wr_count++;
            check("wr_status_strobe", 32'(en_wr_status), 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got result=%h status=%h, expected no write", result, status);
            end else begin
                mon_e = sb.pop_front();
                check("sb_result", result, mon_e.res);
                check("sb_status", status, mon_e.st);
                $display("write: result=%h status=%h (expected %h/%h)", result, status, mon_e.res, mon_e.st);
            end
        end
    end

    function automatic void set_vec(input int i, input logic [2:0] slot, input logic [15:0] xv,
                                    input logic [4:0] deg, input logic [15:0] fill,
                                    input logic [31:0] res, input logic [31:0] st);
        vecs[i].slot = slot;
        vecs[i].xv   = xv;
        vecs[i].deg  = deg;
        for (int k = 0; k < 11; k++) vecs[i].c[k] = fill;
        vecs[i].res  = res;
        vecs[i].st   = st;
    endfunction

    task automatic load_vec(input vec_t v);
        nram[v.slot] = v.deg;
        for (int k = 0; k < 11; k++) sram[int'(v.slot) * 11 + k] = v.c[k];
    endtask

    // Issue one EVP and follow it cycle by cycle (cycle 0 = start sampled).
    task automatic run_evp(input vec_t v, input int extra_start);
        exp_t e;
        int   cyc;
        int   out_cyc;
        int   done_cyc;
        int   nreads;
        int   exp_addr;
        bit   valid;
        valid = (v.deg <= 5'd10);
        @(negedge clk);
        A = v.slot;
        x = v.xv;
        start_evp = 1'b1;
        e.res = v.res;
        e.st  = v.st;
        sb.push_back(e);
        @(negedge clk);
        start_evp = 1'b0;
        // Operands must have been latched; scramble the pins.
        A = ~v.slot;
        x = 16'($urandom);
        cyc = 1;
        out_cyc = -1;
        done_cyc = -1;
        nreads = 0;
        while (done_cyc < 0 && cyc < 60) begin
            if (cyc == 1) begin
                check("n_read_en", 32'(en_rd_N), 32'd1);
                check("n_read_addr", 32'(rd_addr_N), 32'(v.slot));
            end
            if (en_rd_S) begin
                exp_addr = int'(v.slot) * 11 + int'(v.deg) - nreads;
                check("s_read_addr", 32'(rd_addr_S), 32'(exp_addr));
                nreads++;
            end
            if (en_wr_result) out_cyc = cyc;
            if (done_evp) begin
                done_cyc = cyc;
                check("result_hold", result, v.res);
            end
            start_evp = (cyc == extra_start);
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start_evp = 1'b0;
        check("out_cycle", 32'(out_cyc), valid ? 32'(2 * int'(v.deg) + 5) : 32'd4);
        check("done_cycle", 32'(done_cyc), valid ? 32'(2 * int'(v.deg) + 6) : 32'd5);
        check("s_read_count", 32'(nreads), valid ? 32'(int'(v.deg) + 1) : 32'd0);
        $display("evp slot=%0d x=%h deg=%0d: out@%0d done@%0d reads=%0d", v.slot, v.xv, v.deg,
                 out_cyc, done_cyc, nreads);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_status"}, status, 32'hFFFF_FFFF);
        check({tag, "_strobes"}, {26'd0, en_rd_N, en_rd_S, en_wr_result, en_wr_status, done_evp, 1'b0}, 32'd0);
        check({tag, "_addrs"}, {22'd0, rd_addr_N, rd_addr_S}, 32'd0);
    endtask

    int wr_before;

    initial begin
        rst = 1'b0;
        start_evp = 1'b0;
        A = '0;
        x = '0;
        for (int k = 0; k < 8; k++) nram[k] = 5'b11111;
        for (int k = 0; k < 88; k++) sram[k] = 16'hDEAD;

        set_vec(0, 3'd1, 16'd5,      5'd2,  16'd0, 32'd38,         32'd0);
        vecs[0].c[0] = 16'd3; vecs[0].c[1] = 16'd2; vecs[0].c[2] = 16'd1;
        set_vec(1, 3'd0, 16'd1234,   5'd0,  16'd0, 32'd7,          32'd0);
        vecs[1].c[0] = 16'd7;
        set_vec(2, 3'd4, 16'd9,      5'd31, 16'd0, 32'd0,          32'd2);
        set_vec(3, 3'd2, 16'hFFFF,   5'd3,  16'd0, 32'hFFFC_0001,  32'd1);
        vecs[3].c[3] = 16'hFFFF;
        set_vec(4, 3'd7, 16'd1,      5'd10, 16'd1, 32'd11,         32'd0);
        set_vec(5, 3'd3, 16'd3,      5'd1,  16'd0, 32'd34,         32'd0);
        vecs[5].c[0] = 16'd4; vecs[5].c[1] = 16'd10;
        set_vec(6, 3'd5, 16'd2,      5'd11, 16'd1, 32'd0,          32'd2);
        set_vec(7, 3'd6, 16'd0,      5'd4,  16'd5, 32'd9,          32'd0);
        vecs[7].c[0] = 16'd9;
        for (int i = 0; i < 8; i++) load_vec(vecs[i]);

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Table-driven EVPs, issued back to back
        for (int i = 0; i < 8; i++) run_evp(vecs[i], 0);

        // Reset during the second MAC of a degree-2 EVP (cycle 6)
        wr_before = wr_count;
        @(negedge clk);
        A = 3'd1;
        x = 16'd5;
        start_evp = 1'b1;
        @(negedge clk);
        start_evp = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_evp), 32'd0);
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_write", 32'(wr_count - wr_before), 32'd0);
        check("abort_status_held", status, 32'hFFFF_FFFF);

        // Same operands again, with a stray start pulse during RD_C (cycle 3)
        wr_before = wr_count;
        run_evp(vecs[0], 3);
        repeat (20) @(negedge clk);
        check("single_write", 32'(wr_count - wr_before), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
